// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, header width,
// instruction word size and the per-state status-flag decode.
package imem_pkg;

    localparam int LEN_W      = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    // Status outputs held while resident in a state: {ready, cpu_hold, done, error}.
    function automatic logic [3:0] state_flags(input state_t s);
        case (s)
            LEN_HI, LEN_LO, DATA, CSUM: state_flags = 4'b1100;
            DONE:                       state_flags = 4'b0010;
            ERROR:                      state_flags = 4'b0101;
            default:                    state_flags = 4'b0100;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream (valid/ready) and instruction-memory byte-write bundles used by imem_loader.
interface imem_stream_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

interface imem_wr_if #(
    parameter int ADDR_W = 10
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input we, input addr, input wdata);
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian program byte stream into instruction memory and holds the
// CPU until the image is complete. Optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | expecting length bits 15:8
// LEN_LO | expecting length bits 7:0, then validate
// DATA   | writing data bytes to consecutive addresses
// CSUM   | expecting XOR checksum of the data bytes
// DONE   | image complete, CPU released
// ERROR  | bad length or checksum, CPU held
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    imem_stream_if.slave    s,
    imem_wr_if.master       mem,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] byte_count
);

    localparam int MEM_CAP = (1 << ADDR_W) - BASE_ADDR;
    localparam int ALIGN_W = $clog2(WORD_BYTES);

    state_t           state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len;
    logic [7:0]       csum;

    logic             xfer;
    logic [LEN_W-1:0] len_full;
    logic             last_byte;

    assign xfer      = s.valid && s.ready;
    assign len_full  = {len_hi, s.data};
    assign last_byte = (LEN_W'(byte_count) + LEN_W'(1)) == len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                           <= IDLE;
            {s.ready, cpu_hold, done, error} <= state_flags(IDLE);
            mem.we                          <= 1'b0;
            mem.addr                        <= ADDR_W'(BASE_ADDR);
            mem.wdata                       <= 8'h00;
            byte_count                      <= '0;
            len_hi                          <= 8'h00;
            len                             <= '0;
            csum                            <= 8'h00;
        end else begin
            mem.we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state                           <= LEN_HI;
                        {s.ready, cpu_hold, done, error} <= state_flags(LEN_HI);
                        byte_count                      <= '0;
                        csum                            <= 8'h00;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= s.data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len <= len_full;
                        // Zero length completes immediately; misaligned or oversize images are rejected.
                        if (len_full == '0) begin
                            state                           <= DONE;
                            {s.ready, cpu_hold, done, error} <= state_flags(DONE);
                        end else if ((len_full[ALIGN_W-1:0] != '0) ||
                                     (32'(len_full) > 32'(MEM_CAP))) begin
                            state                           <= ERROR;
                            {s.ready, cpu_hold, done, error} <= state_flags(ERROR);
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        mem.we     <= 1'b1;
                        mem.addr   <= ADDR_W'(BASE_ADDR) + byte_count[ADDR_W-1:0];
                        mem.wdata  <= s.data;
                        byte_count <= byte_count + (ADDR_W+1)'(1);
                        csum       <= csum ^ s.data;
                        if (last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            // done is presented in the same cycle as the final write.
                            state                           <= DONE;
                            {s.ready, cpu_hold, done, error} <= state_flags(DONE);
`endif
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (s.data == csum) begin
                            state                           <= DONE;
                            {s.ready, cpu_hold, done, error} <= state_flags(DONE);
                        end else begin
                            state                           <= ERROR;
                            {s.ready, cpu_hold, done, error} <= state_flags(ERROR);
                        end
                    end
                end
                default: begin
                    state                           <= IDLE;
                    {s.ready, cpu_hold, done, error} <= state_flags(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum cases run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [ADDR_W:0] byte_count;

    imem_stream_if                    s_if ();
    imem_wr_if #(.ADDR_W(ADDR_W))     m_if ();

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s          (s_if.slave),
        .mem        (m_if.master),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]        mem [0:1023];
    logic [ADDR_W-1:0] wr_addr [$];
    logic [7:0]        wr_data [$];

    always @(posedge clk) begin
        if (m_if.we) begin
            mem[m_if.addr] <= m_if.wdata;
            wr_addr.push_back(m_if.addr);
            wr_data.push_back(m_if.wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        s_if.valid = 1'b1;
        s_if.data  = b;
        while (!s_if.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL send_timeout: waited %0d cycles, required < 100", n);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.data  = 8'hA5;
    endtask

    task automatic send_seq(input logic [7:0] seq [$], input int max_gap);
        foreach (seq[i]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send(seq[i]);
        end
    endtask

    task automatic check_writes(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_count"}, wr_addr.size(), exp.size());
        foreach (exp[i]) begin
            if (i < wr_addr.size()) begin
                chk({tag, "_addr"}, 32'(wr_addr[i]), i);
                chk({tag, "_data"}, 32'(wr_data[i]), 32'(exp[i]));
            end
        end
    endtask

    logic [7:0] img [$];
    logic [7:0] part [$];

    initial begin
        img  = '{8'h21, 8'h08, 8'h00, 8'h00, 8'h21, 8'h29, 8'h00, 8'h01};
        part = '{8'h21, 8'h08, 8'h00};
        s_if.valid = 1'b0;
        s_if.data  = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", s_if.ready, 0);
        chk("rst_we", m_if.we, 0);
        chk("rst_addr", m_if.addr, 0);
        chk("rst_wdata", m_if.wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", byte_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", s_if.ready, 0);

        // 1: back-to-back 8-byte image
        clear_log();
        pulse_start();
        chk("t1_ready", s_if.ready, 1);
        send(8'h00);
        send(8'h08);
        chk("t1_hold_in_data", cpu_hold, 1);
        send_seq(img, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t1_done_before_csum", done, 0);
        send(8'h20);
`else
        chk("t1_last_we", m_if.we, 1);
        chk("t1_last_addr", m_if.addr, 7);
`endif
        chk("t1_done", done, 1);
        chk("t1_hold", cpu_hold, 0);
        chk("t1_error", error, 0);
        chk("t1_count", byte_count, 8);
        chk("t1_ready_off", s_if.ready, 0);
        @(negedge clk);
        check_writes("t1", img);
        chk("t1_fetch4", {mem[4], mem[5], mem[6], mem[7]}, 32'h21290001);
        chk("t1_fetch0", {mem[0], mem[1], mem[2], mem[3]}, 32'h21080000);

        // 2: same image with gaps and a stray start mid-load
        clear_log();
        pulse_start();
        chk("t2_done_clr", done, 0);
        chk("t2_count_clr", byte_count, 0);
        chk("t2_hold", cpu_hold, 1);
        send_seq('{8'h00, 8'h08}, 2);
        send_seq(img[0:3], 2);
        pulse_start();
        chk("t2_stray_ready", s_if.ready, 1);
        chk("t2_stray_count", byte_count, 4);
        send_seq(img[4:7], 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h20);
`endif
        chk("t2_done", done, 1);
        @(negedge clk);
        check_writes("t2", img);

        // 3: misaligned length
        clear_log();
        pulse_start();
        send(8'h00);
        send(8'h06);
        chk("t3_error", error, 1);
        chk("t3_done", done, 0);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_ready", s_if.ready, 0);
        repeat (2) @(negedge clk);
        chk("t3_no_writes", wr_addr.size(), 0);

        // 4: oversize length, then zero length
        pulse_start();
        chk("t4_error_clr", error, 0);
        send(8'h04);
        send(8'h04);
        chk("t4_big_error", error, 1);
        chk("t4_big_hold", cpu_hold, 1);
        pulse_start();
        send(8'h00);
        send(8'h00);
        chk("t4_zero_done", done, 1);
        chk("t4_zero_error", error, 0);
        chk("t4_zero_hold", cpu_hold, 0);
        chk("t4_zero_count", byte_count, 0);
        repeat (2) @(negedge clk);
        chk("t4_no_writes", wr_addr.size(), 0);

        // 5: reset after three data bytes, then reload
        clear_log();
        pulse_start();
        send(8'h00);
        send(8'h08);
        send_seq(part, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_ready", s_if.ready, 0);
        chk("t5_we", m_if.we, 0);
        chk("t5_addr", m_if.addr, 0);
        chk("t5_wdata", m_if.wdata, 0);
        chk("t5_hold", cpu_hold, 1);
        chk("t5_done", done, 0);
        chk("t5_count", byte_count, 0);
        check_writes("t5_partial", part);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        send(8'h00);
        send(8'h08);
        send_seq(img, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h20);
`endif
        chk("t5_reload_done", done, 1);
        @(negedge clk);
        check_writes("t5_reload", img);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        pulse_start();
        send_seq('{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
        chk("t6_wait_csum", done, 0);
        send(8'h04);
        chk("t6_good_done", done, 1);
        chk("t6_good_error", error, 0);
        pulse_start();
        send_seq('{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
        send(8'h05);
        chk("t6_bad_error", error, 1);
        chk("t6_bad_done", done, 0);
        chk("t6_bad_hold", cpu_hold, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
